// File: rtl/countdown_seq_ctrl_pkg.sv
// Shared definitions for the countdown sequencer: run-state encodings and alarm defaults.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ALARM_CNT_W = 4;
  localparam logic [ALARM_CNT_W-1:0] ALARM_TICKS_DEFAULT = 4'd8;

endpackage

// File: rtl/countdown_seq_ctrl_debounce.sv
// Button conditioner: two-flop synchronizer, stability-count debounce and
// rising-edge detect producing a single-cycle press pulse.
module btn_debounce #(
  parameter int DEB_W = 16,
  parameter logic [DEB_W-1:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_CYCLES - DEB_W'(1);

  logic             sync_meta;
  logic             sync_lvl;
  logic             level;
  logic             level_d;
  logic [DEB_W-1:0] stable_cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_lvl  <= sync_meta;
    end
  end

  // Accept a new level only after it has differed from the old one for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_lvl != level) begin
      if (stable_cnt == DEB_LAST) begin
        level      <= sync_lvl;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DEB_W'(1);
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  // Registered 0->1 detect on the accepted level gives a clean one-cycle press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/countdown_seq_ctrl.sv
// Run-state sequencer for the BCD countdown: start/pause/reload control,
// count-enable gating, reload strobes and the end-of-count alarm blink.
module countdown_seq_ctrl
  import countdown_pkg::*;
#(
  parameter int DEB_W = 16,
  parameter logic [DEB_W-1:0] DEB_CYCLES = 16'd50000,
  parameter logic [ALARM_CNT_W-1:0] ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_load,
  input  logic       cnt_zero,
  output logic       cnt_en,
  output logic       cnt_load,
  output logic       disp_blank,
  output logic       alarm,
  output logic [1:0] state
);

  state_t                 state_q;
  state_t                 state_d;
  logic                   start_p;
  logic                   load_p;
  logic                   load_req;
  logic                   enter_done;
  logic                   alarm_step;
  logic                   preset_q;
  logic                   cnt_load_q;
  logic                   alarm_q;
  logic                   blank_q;
  logic [ALARM_CNT_W-1:0] alarm_cnt_q;

  btn_debounce #(
    .DEB_W      (DEB_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_p)
  );

  btn_debounce #(
    .DEB_W      (DEB_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_load (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_load),
    .press (load_p)
  );

  // Run-state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; reload beats start, and start beats tick.
  always_comb begin
    state_d    = state_q;
    cnt_en     = 1'b0;
    load_req   = 1'b0;
    enter_done = 1'b0;
    alarm_step = 1'b0;
    if (load_p) begin
      state_d  = ST_IDLE;
      load_req = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (start_p) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (cnt_zero) begin
              state_d    = ST_DONE;
              enter_done = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start_p) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start_p || (alarm_cnt_q == ALARM_TICKS)) begin
            state_d  = ST_IDLE;
            load_req = 1'b1;
          end else if (tick) begin
            alarm_step = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reload strobe (including the one-shot preset after reset) and alarm blink bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset_q    <= 1'b1;
      cnt_load_q  <= 1'b0;
      alarm_q     <= 1'b0;
      blank_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      preset_q   <= 1'b0;
      cnt_load_q <= load_req | preset_q;
      if (load_req) begin
        alarm_q <= 1'b0;
        blank_q <= 1'b0;
      end else if (enter_done) begin
        alarm_q     <= 1'b0;
        blank_q     <= 1'b0;
        alarm_cnt_q <= '0;
      end else if (alarm_step) begin
        alarm_q     <= ~alarm_q;
        blank_q     <= ~alarm_q;
        alarm_cnt_q <= alarm_cnt_q + ALARM_CNT_W'(1);
      end
    end
  end

  assign cnt_load   = cnt_load_q;
  assign alarm      = alarm_q;
  assign disp_blank = blank_q;
  assign state      = state_q;

endmodule

// File: doc/countdown_seq_ctrl.md
Name: countdown_seq_ctrl

Overview:
- Sequencer for the 3-digit BCD countdown datapath (123 -> 000 counter, freq dividers, seg7 scan).
- Converts two raw push-buttons into a start/pause/reload run-state machine.
- Gates the slow count tick into a one-cycle count enable and issues reload strobes.
- Drives a timed end-of-count alarm with display blink.
- Sits between board buttons/divider outputs and the counter's enable/load inputs.

Parameters:
- DEB_CYCLES, 16'd50000: clk cycles a synchronized button level must stay stable before it is accepted.
- DEB_W, 16: width of the debounce counter; DEB_CYCLES must be < 2^DEB_W.
- ALARM_TICKS, 4'd8: number of tick pulses spent in DONE before auto-reload.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk-wide pulse at count rate, synchronous to clk.
- btn_start  in  1  raw start/pause button, active-high, asynchronous.
- btn_load  in  1  raw reload button, active-high, asynchronous.
- cnt_zero  in  1  datapath at 000; the counter's carry output.
- cnt_en  out  1  one-cycle count-down enable to the datapath.
- cnt_load  out  1  one-cycle reload-to-preset strobe to the datapath.
- disp_blank  out  1  1 = blank all digits.
- alarm  out  1  alarm LED; toggles during DONE.
- state  out  2  current FSM state encoding, for LEDs and debug.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt_en=0, disp_blank=0, alarm=0. Synchronizers and debouncers are cleared. The alarm tick counter is 0.
- First clk edge after reset release: cnt_load=1 for exactly one cycle. This guarantees the datapath preset.
- Button path: 2-FF synchronizer, then debounce, then rising-edge detect.
  - Debounce: the accepted level updates after DEB_CYCLES consecutive cycles of equal synced level. Any change restarts the count.
  - Output: one-cycle press pulse (start_p, load_p) on an accepted 0->1 transition.
  - Latency from a clean raw edge to the press pulse is DEB_CYCLES+3 clk.
- States: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
- IDLE: start_p -> RUN. tick is ignored.
- RUN:
  - On tick with cnt_zero=0: cnt_en=1 in the same cycle as tick, combinational from registered state.
  - On tick with cnt_zero=1: go to DONE, cnt_en=0, clear the alarm counter.
  - start_p -> PAUSE.
- PAUSE: start_p -> RUN. tick is ignored, cnt_en=0.
- DONE:
  - On each tick: alarm toggles, disp_blank is set to the new alarm value, and the alarm counter increments.
  - When the counter reaches ALARM_TICKS, or on start_p: cnt_load=1, go to IDLE, alarm=0, disp_blank=0.
- load_p in any state: cnt_load=1 for one cycle, go to IDLE, alarm=0, disp_blank=0.
- Priorities:
  - load_p beats start_p.
  - start_p beats tick in the same cycle: in RUN, pause wins and there is no cnt_en.
- cnt_en and cnt_load are never high in the same cycle. cnt_en is high only in RUN.
- A continuous tick with both buttons held produces no repeated presses; each press needs an accepted release then press.
- Reset mid-run: immediate IDLE, then one cnt_load on release.

Decomposition:
- Shared package countdown_pkg: state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE) and a default ALARM_TICKS constant.
- One sub-module, btn_debounce (sync + debounce + edge detect, parameters DEB_CYCLES/DEB_W), instantiated twice.
- The FSM, output gating and alarm counter live in the top.

Test Plan:
- Reset release -> cnt_load high exactly cycle 1, state=0, alarm=0, disp_blank=0.
- DEB_CYCLES=4: btn_start bounced 1-0-1 within 3 cycles, then held -> a single start_p, state=1. Each following tick gives a same-cycle cnt_en, counted as 5 pulses for 5 ticks.
- In RUN, start press coincident with tick -> state=2 and no cnt_en that cycle. 3 ticks in PAUSE -> 0 cnt_en. Second press -> state=1.
- RUN with cnt_zero=1 on tick -> state=3, no cnt_en. 8 ticks -> alarm toggles 8 times, disp_blank follows alarm, then cnt_load=1 and state=0.
- btn_load and btn_start pressed the same cycle while in RUN -> cnt_load=1, state=0, no transition to PAUSE.
- reset asserted in DONE with alarm=1 -> alarm=0, disp_blank=0, state=0 asynchronously, before the next clk edge.
